// File: rtl/pll_hdmi_reconfig_seq.sv
// Reprograms the HDMI PLL through its reconfig controller's Avalon-MM management port,
// then waits for relock and reports done or a relock timeout.
module pll_hdmi_reconfig_seq #(
  parameter int LOCK_TIMEOUT  = 5000000,
  parameter int SETTLE_CYCLES = 16,
  parameter int C_SEL         = 0
) (
  input  logic        mgmt_clk,
  input  logic        mgmt_reset_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_c0,
  input  logic [31:0] cfg_k,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX   = TW'(LOCK_TIMEOUT);
  localparam logic [SW-1:0] S_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [4:0]    C_SEL_F = 5'(C_SEL);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_MODE, S_WR_N, S_WR_M, S_WR_C, S_WR_K, S_WR_START, S_SETTLE, S_WAIT_LOCK
  } state_t;

  state_t        state_q, state_d, nxt_state;
  logic          ready_q, ready_d;
  logic          write_q, write_d;
  logic [5:0]    addr_q, addr_d, nxt_addr;
  logic [31:0]   wdata_q, wdata_d, nxt_data;
  logic          done_q, done_d, error_q, error_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          sync1_q, sync2_q;
  logic [17:0]   n_q, n_d, m_q, m_d, c0_q, c0_d;
  logic [31:0]   k_q, k_d;

  always_ff @(posedge mgmt_clk or negedge mgmt_reset_n) begin
    if (!mgmt_reset_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      scnt_q  <= '0;
      tcnt_q  <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      error_q <= error_d;
      scnt_q  <= scnt_d;
      tcnt_q  <= tcnt_d;
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  // Descriptor holding registers carry data only; they are qualified by the FSM.
  always_ff @(posedge mgmt_clk) begin
    n_q  <= n_d;
    m_q  <= m_d;
    c0_q <= c0_d;
    k_q  <= k_d;
  end

  // Write that follows the current WR_* state in the fixed programming order.
  always_comb begin
    nxt_state = S_IDLE;
    nxt_addr  = '0;
    nxt_data  = '0;
    case (state_q)
      S_WR_MODE:  begin nxt_state = S_WR_N;     nxt_addr = 6'h03; nxt_data = {14'b0, n_q}; end
      S_WR_N:     begin nxt_state = S_WR_M;     nxt_addr = 6'h04; nxt_data = {14'b0, m_q}; end
      S_WR_M:     begin nxt_state = S_WR_C;     nxt_addr = 6'h05; nxt_data = {9'b0, C_SEL_F, c0_q}; end
      S_WR_C:     begin nxt_state = S_WR_K;     nxt_addr = 6'h07; nxt_data = k_q; end
      S_WR_K:     begin nxt_state = S_WR_START; nxt_addr = 6'h02; nxt_data = 32'd1; end
      S_WR_START: nxt_state = S_SETTLE;
      default:    nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    scnt_d  = scnt_q;
    tcnt_d  = tcnt_q;
    n_d     = n_q;
    m_d     = m_q;
    c0_d    = c0_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (cfg_valid && ready_q) begin
          ready_d = 1'b0;
          state_d = S_WR_MODE;
          write_d = 1'b1;
          addr_d  = 6'h00;
          wdata_d = 32'd0;
          n_d     = cfg_n;
          m_d     = cfg_m;
          c0_d    = cfg_c0;
          k_d     = cfg_k;
        end
      end
      // Each write: strobe until accepted, then one idle cycle before moving on.
      S_WR_MODE, S_WR_N, S_WR_M, S_WR_C, S_WR_K, S_WR_START: begin
        if (write_q) begin
          if (!mgmt_waitrequest) write_d = 1'b0;
        end else begin
          state_d = nxt_state;
          if (nxt_state == S_SETTLE) begin
            scnt_d = '0;
          end else begin
            write_d = 1'b1;
            addr_d  = nxt_addr;
            wdata_d = nxt_data;
          end
        end
      end
      S_SETTLE: begin
        if (scnt_q == S_LAST) begin
          state_d = S_WAIT_LOCK;
          tcnt_d  = '0;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (sync2_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (tcnt_q == T_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else if (tcnt_q != T_MAX) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_ready      = ready_q;
  assign busy           = ~ready_q;
  assign mgmt_write     = write_q;
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = wdata_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule
